// File: rtl/led_frame_feeder_if.sv
// rtl/led_frame_feeder_if.sv - host write, commit and pixel stream bundle for led_frame_feeder
interface led_frame_feeder_if #(parameter int ADDR_W = 7);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              commit;
  logic              commit_pending;
  logic [7:0]        bright;
  logic              frame_req;
  logic              busy;
  logic              pix_valid;
  logic              pix_ready;
  logic [23:0]       pix_data;
  logic              pix_last;
  logic              frame_done;

  // master: the feeder itself; slave: host plus LED driver
  modport master (
    input  wr_en, wr_addr, wr_data, commit, bright, frame_req, pix_ready,
    output commit_pending, busy, pix_valid, pix_data, pix_last, frame_done
  );
  modport slave (
    output wr_en, wr_addr, wr_data, commit, bright, frame_req, pix_ready,
    input  commit_pending, busy, pix_valid, pix_data, pix_last, frame_done
  );
endinterface

// File: rtl/led_frame_feeder.sv
// rtl/led_frame_feeder.sv - ping-pong frame buffer streaming brightness-scaled GRB pixels
module led_frame_feeder #(
  parameter int NUM_LEDS = 100,
  parameter int ADDR_W   = 7
) (
  input  logic               sys_clk,
  input  logic               sys_nrst,
  led_frame_feeder_if.master bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_SC   = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        bright_q, bright_d;
  logic              fsel_q, fsel_d;
  logic              pend_q, pend_d;
  logic [23:0]       pix_data_q, pix_data_d;
  logic              pix_last_q, pix_last_d;
  logic [23:0]       mem [2][NUM_LEDS];
  logic [23:0]       rd_data_q;

  // (c * (b + 1)) >> 8: b = 255 passes c through unchanged, b = 0 blanks it
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] prod;
    prod = {9'd0, c} * {8'd0, ({1'b0, b} + 9'd1)};
    return 8'(prod >> 8);
  endfunction

  always_ff @(posedge sys_clk) begin
    if (bus.wr_en && (bus.wr_addr <= LAST_ADDR))
      mem[~fsel_q][bus.wr_addr] <= bus.wr_data;
    if (state_q == S_RD)
      rd_data_q <= mem[fsel_q][rd_addr_q];
  end

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    bright_d   = bright_q;
    fsel_d     = fsel_q;
    pend_d     = pend_q;
    pix_data_d = pix_data_q;
    pix_last_d = pix_last_q;
    case (state_q)
      S_IDLE: begin
        if (bus.frame_req) begin
          bright_d  = bus.bright;
          rd_addr_d = '0;
          state_d   = S_RD;
          if (bus.commit)
            pend_d = 1'b1;
        end else if (bus.commit) begin
          fsel_d = ~fsel_q;
        end
      end
      S_RD: state_d = S_SC;
      S_SC: begin
        pix_data_d = {scale_ch(rd_data_q[23:16], bright_q),
                      scale_ch(rd_data_q[15:8], bright_q),
                      scale_ch(rd_data_q[7:0], bright_q)};
        pix_last_d = (rd_addr_q == LAST_ADDR);
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (bus.pix_ready) begin
          if (pix_last_q) begin
            state_d = S_DONE;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = S_RD;
          end
        end
      end
      S_DONE: begin
        // a commit arriving on this very cycle folds into the boundary swap
        if (pend_q || bus.commit)
          fsel_d = ~fsel_q;
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.commit && (state_q inside {S_RD, S_SC, S_OUT}))
      pend_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      bright_q   <= '0;
      fsel_q     <= 1'b0;
      pend_q     <= 1'b0;
      pix_data_q <= '0;
      pix_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      bright_q   <= bright_d;
      fsel_q     <= fsel_d;
      pend_q     <= pend_d;
      pix_data_q <= pix_data_d;
      pix_last_q <= pix_last_d;
    end
  end

  assign bus.commit_pending = pend_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.pix_valid      = (state_q == S_OUT);
  assign bus.pix_data       = pix_data_q;
  assign bus.pix_last       = pix_last_q;
  assign bus.frame_done     = (state_q == S_DONE);
endmodule

// File: tb/tb_led_frame_feeder.sv
// tb/tb_led_frame_feeder.sv - directed/random bench for led_frame_feeder against a buffer-level model
`timescale 1ns/1ps
module tb_led_frame_feeder;
  localparam int N = 100;

  logic sys_clk;
  logic sys_nrst;
  led_frame_feeder_if #(.ADDR_W(7)) bus ();
  led_frame_feeder #(.NUM_LEDS(N), .ADDR_W(7)) dut (
    .sys_clk (sys_clk),
    .sys_nrst(sys_nrst),
    .bus     (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [23:0] bufm [2][N];
  int          front_m = 0;
  bit          pend_m = 1'b0;
  logic [23:0] px0;

  initial sys_clk = 1'b0;
  always #50 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] scale_m(input logic [23:0] p, input int b);
    int g, r, bl;
    g  = int'(p[23:16]) * (b + 1) / 256;
    r  = int'(p[15:8])  * (b + 1) / 256;
    bl = int'(p[7:0])   * (b + 1) / 256;
    return {g[7:0], r[7:0], bl[7:0]};
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.pix_valid, 0);
    chk("rst_done", bus.frame_done, 0);
    chk("rst_pending", bus.commit_pending, 0);
    chk("rst_data", bus.pix_data, 0);
    chk("rst_last", bus.pix_last, 0);
  endtask

  task automatic host_write(input int a, input logic [23:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = 7'(a); bus.wr_data = d;
    if (a < N) bufm[1 - front_m][a] = d;
    @(negedge sys_clk);
    bus.wr_en = 1'b0;
  endtask

  // mode 0: pixel i = {i, 80, FF}; mode 1: random; plus a few ignored out-of-range writes
  task automatic fill_back(input int mode);
    for (int i = 0; i < N; i++)
      host_write(i, (mode == 0) ? {8'(i), 8'h80, 8'hFF} : 24'($urandom));
    for (int k = 0; k < 3; k++)
      host_write($urandom_range(N, 127), 24'($urandom));
  endtask

  task automatic commit_idle();
    bus.commit = 1'b1;
    @(negedge sys_clk);
    bus.commit = 1'b0;
    front_m = 1 - front_m;
    chk("idle_commit_no_pending", bus.commit_pending, 0);
  endtask

  task automatic run_frame(input int b, input int stall_pct, input int commit_at, input int ncommit,
                           input bit commit_with_req, input int req_mid_at, input bit wr_mid,
                           input int rst_at, output logic [23:0] first_pix);
    logic [23:0] expv [N];
    logic [23:0] hold_d, d;
    logic        hold_l;
    bit          stalled, done, rdy, commit_fired, req_fired;
    int          idx, cyc, first_cyc, commit_left, a;
    for (int i = 0; i < N; i++) expv[i] = scale_m(bufm[front_m][i], b);
    idx = 0; cyc = 0; first_cyc = -1; commit_left = 0; first_pix = '0;
    stalled = 0; done = 0; commit_fired = 0; req_fired = 0; hold_d = '0; hold_l = 1'b0;
    bus.bright = 8'(b);
    bus.frame_req = 1'b1;
    if (commit_with_req) begin bus.commit = 1'b1; pend_m = 1'b1; end
    while (!done && cyc < 3000) begin
      @(negedge sys_clk);
      cyc++;
      bus.frame_req = 1'b0; bus.commit = 1'b0; bus.wr_en = 1'b0;
      bus.bright = 8'($urandom);
      if (bus.frame_done) begin
        done = 1;
        chk("pending_at_done", bus.commit_pending, pend_m);
        chk("pixel_count", idx, N);
        chk("first_valid_latency", first_cyc, 3);
      end else begin
        if (stalled) begin
          chk("stall_valid_held", bus.pix_valid, 1);
          chk("stall_data_held", bus.pix_data, hold_d);
          chk("stall_last_held", bus.pix_last, hold_l);
        end else if (bus.pix_valid) begin
          if (first_cyc < 0) begin first_cyc = cyc; first_pix = bus.pix_data; end
          if (idx < N) begin
            chk($sformatf("pix_data[%0d]", idx), bus.pix_data, expv[idx]);
            chk($sformatf("pix_last[%0d]", idx), bus.pix_last, (idx == N - 1));
          end else begin
            chk("pixel_overrun", idx, N - 1);
          end
        end
        if (rst_at >= 0 && idx == rst_at && bus.pix_valid) begin
          sys_nrst = 1'b0;
          bus.pix_ready = 1'b0;
          #1;
          chk_reset_outputs();
          front_m = 0; pend_m = 1'b0;
          return;
        end
        if (bus.pix_valid && !commit_fired && idx == commit_at) begin
          commit_fired = 1; commit_left = ncommit;
        end
        if (commit_left > 0) begin bus.commit = 1'b1; commit_left--; pend_m = 1'b1; end
        if (bus.pix_valid && !req_fired && idx == req_mid_at) begin
          req_fired = 1; bus.frame_req = 1'b1;
        end
        if (wr_mid) begin
          a = $urandom_range(0, 127); d = 24'($urandom);
          bus.wr_en = 1'b1; bus.wr_addr = 7'(a); bus.wr_data = d;
          if (a < N) bufm[1 - front_m][a] = d;
        end
        rdy = ($urandom_range(0, 99) >= stall_pct);
        bus.pix_ready = rdy;
        if (bus.pix_valid) begin
          stalled = !rdy;
          hold_d = bus.pix_data; hold_l = bus.pix_last;
          if (rdy) idx++;
        end else begin
          stalled = 0;
        end
      end
    end
    chk("frame_completed", done, 1);
    bus.pix_ready = 1'b0;
    if (pend_m) begin front_m = 1 - front_m; pend_m = 1'b0; end
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      chk("post_frame_idle", bus.busy, 0);
    end
    chk("done_single_pulse", bus.frame_done, 0);
    chk("pending_cleared", bus.commit_pending, 0);
  endtask

  initial begin
    sys_nrst = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.commit = 1'b0;
    bus.bright = '0; bus.frame_req = 1'b0; bus.pix_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_reset_outputs();
    sys_nrst = 1'b1;
    @(negedge sys_clk);

    fill_back(0);
    commit_idle();
    run_frame(255, 0, -1, 0, 0, -1, 0, -1, px0);
    chk("identity_px0", px0, 24'h0080FF);

    fill_back(1);
    host_write(0, 24'hFF8040);
    commit_idle();
    run_frame(127, 0, -1, 0, 0, -1, 0, -1, px0);
    chk("bright127_px0", px0, 24'h7F4020);
    run_frame(0, 0, -1, 0, 0, -1, 0, -1, px0);
    chk("bright0_px0", px0, 24'h000000);

    run_frame($urandom_range(0, 255), 50, -1, 0, 0, -1, 0, -1, px0);

    fill_back(1);
    run_frame(255, 30, 40, 1, 0, -1, 1, -1, px0);
    run_frame(255, 0, -1, 0, 0, -1, 0, -1, px0);

    fill_back(1);
    run_frame(200, 20, 10, 2, 0, 20, 0, -1, px0);
    run_frame(255, 0, -1, 0, 0, -1, 0, -1, px0);

    fill_back(1);
    run_frame(255, 0, -1, 0, 1, -1, 0, -1, px0);
    run_frame(255, 10, -1, 0, 0, -1, 0, -1, px0);

    fill_back(1);
    run_frame(255, 0, 10, 1, 0, -1, 0, 50, px0);
    @(negedge sys_clk);
    sys_nrst = 1'b1;
    @(negedge sys_clk);
    chk("post_reset_pending", bus.commit_pending, 0);
    run_frame(255, 0, -1, 0, 0, -1, 0, -1, px0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
